// File: rtl/tl_ul_sram_responder.sv
// rtl/tl_ul_sram_responder.sv - TileLink-UL single-beat SRAM responder
//
// Terminates TileLink-UL channel A and answers on channel D from a
// word-addressed SRAM of DEPTH 32-bit words mapped at BASE_ADDR.
// Get, PutFullData and PutPartialData are served. Any other request is
// answered with a denied response.
//
// Ports:
//   clock, reset              sole clock, synchronous active-high reset
//   a_valid/a_ready           channel A handshake
//   a_opcode/a_param/a_size   request kind, param (ignored), log2 bytes
//   a_source/a_address        requester id, byte address
//   a_mask/a_data             byte lanes, write data
//   d_valid/d_ready           channel D handshake
//   d_opcode/d_param/d_size   AccessAck(0)/AccessAckData(1), 0, echo size
//   d_source                  echo of accepted a_source
//   d_denied/d_corrupt/d_data refusal flag, data-invalid flag, read data
module tl_ul_sram_responder #(
  parameter int                ADDR_W    = 32,
  parameter int                SOURCE_W  = 4,
  parameter int                DEPTH     = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [2:0]          a_param,
  input  logic [1:0]          a_size,
  input  logic [SOURCE_W-1:0] a_source,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic [3:0]          a_mask,
  input  logic [31:0]         a_data,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [2:0]          d_opcode,
  output logic [1:0]          d_param,
  output logic [1:0]          d_size,
  output logic [SOURCE_W-1:0] d_source,
  output logic                d_denied,
  output logic                d_corrupt,
  output logic [31:0]         d_data
);

  localparam int IDX_W = $clog2(DEPTH);
  // One extra bit so the end-of-region bound cannot wrap.
  localparam logic [ADDR_W:0] END_ADDR = {1'b0, BASE_ADDR} + (ADDR_W+1)'(DEPTH * 4);

  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_GET         = 3'd4;

  logic [31:0]       mem [DEPTH];
  logic              a_fire;
  logic              is_get;
  logic              op_ok;
  logic              size_ok;
  logic              aligned;
  logic              in_range;
  logic              legal;
  logic [ADDR_W-1:0] offset;
  logic [IDX_W-1:0]  idx;
  logic              unused_bits;

  // Response register either empty or able to drain this cycle.
  assign a_ready = !d_valid || d_ready;
  // A beat presented during reset is ignored entirely.
  assign a_fire  = a_valid && a_ready && !reset;

  assign is_get  = (a_opcode == OP_GET);
  assign op_ok   = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PARTIAL) || is_get;
  assign size_ok = (a_size <= 2'd2);

  always_comb begin
    aligned = 1'b0;
    case (a_size)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = !a_address[0];
      2'd2:    aligned = (a_address[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  assign in_range = ({1'b0, a_address} >= {1'b0, BASE_ADDR}) && ({1'b0, a_address} < END_ADDR);
  assign legal    = op_ok && size_ok && aligned && in_range;

  assign offset = a_address - BASE_ADDR;
  assign idx    = offset[IDX_W+1:2];

  // Byte offset and high offset bits are validated above, not used to index.
  assign unused_bits = ^{a_param, offset};

  // SRAM write port: contents survive reset on purpose.
  always_ff @(posedge clock) begin
    if (a_fire && legal && !is_get) begin
      for (int i = 0; i < 4; i++) begin
        if (a_mask[i]) begin
          mem[idx][8*i +: 8] <= a_data[8*i +: 8];
        end
      end
    end
  end

  // Response register: loads on A fire, empties on D fire without refill.
  always_ff @(posedge clock) begin
    if (reset) begin
      d_valid   <= 1'b0;
      d_opcode  <= 3'd0;
      d_size    <= 2'd0;
      d_source  <= '0;
      d_denied  <= 1'b0;
      d_corrupt <= 1'b0;
      d_data    <= 32'd0;
    end else if (a_fire) begin
      d_valid   <= 1'b1;
      d_opcode  <= is_get ? 3'd1 : 3'd0;
      d_size    <= a_size;
      d_source  <= a_source;
      d_denied  <= !legal;
      // A refused Get still carries a data beat, which is marked corrupt.
      d_corrupt <= !legal && is_get;
      d_data    <= (legal && is_get) ? mem[idx] : 32'd0;
    end else if (d_ready) begin
      d_valid   <= 1'b0;
    end
  end

  assign d_param = 2'd0;

endmodule

// File: tb/tb_tl_ul_sram_responder.sv
// tb/tb_tl_ul_sram_responder.sv - scoreboard bench for tl_ul_sram_responder
module tb_tl_ul_sram_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;

  typedef struct packed {
    logic [2:0]  op;
    logic [1:0]  param;
    logic [1:0]  size;
    logic [3:0]  src;
    logic        den;
    logic        cor;
    logic [31:0] data;
  } rsp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [2:0]  a_opcode = 3'd0;
  logic [2:0]  a_param = 3'd0;
  logic [1:0]  a_size = 2'd0;
  logic [3:0]  a_source = 4'd0;
  logic [31:0] a_address = 32'd0;
  logic [3:0]  a_mask = 4'd0;
  logic [31:0] a_data = 32'd0;
  logic        d_valid;
  logic        d_ready = 1'b1;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [1:0]  d_size;
  logic [3:0]  d_source;
  logic        d_denied;
  logic        d_corrupt;
  logic [31:0] d_data;

  int   total = 0;
  int   bad = 0;
  rsp_t exp_q[$];
  bit   rand_mode = 1'b0;
  logic [31:0] model [8];

  tl_ul_sram_responder dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_denied(d_denied), .d_corrupt(d_corrupt),
    .d_data(d_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic rsp_t mk(input logic [2:0] op, input logic [1:0] size, input logic [3:0] src,
                              input logic den, input logic cor, input logic [31:0] data);
    rsp_t r;
    r.op = op; r.param = 2'd0; r.size = size; r.src = src;
    r.den = den; r.cor = cor; r.data = data;
    return r;
  endfunction

  // Monitor: every D fire is matched against the oldest expected response.
  always @(negedge clock) begin
    if (!reset && d_valid && d_ready) begin
      rsp_t act;
      act = {d_opcode, d_param, d_size, d_source, d_denied, d_corrupt, d_data};
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL d_unexpected: got %h with no response expected", act);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("d_response", 64'(act), 64'(e));
      end
    end
  end

  // Random d_ready back-pressure, active only in the random phase.
  always @(posedge clock) begin
    if (rand_mode) begin
      #1;
      d_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // Present one A beat (caller is at posedge+1), wait for acceptance,
  // queue the expected response and confirm d_valid rises one cycle later.
  task automatic send(input logic [2:0] op, input logic [1:0] size, input logic [31:0] addr,
                      input logic [3:0] mask, input logic [31:0] data, input logic [3:0] src,
                      input rsp_t exp, output int waits);
    a_valid = 1'b1; a_opcode = op; a_size = size; a_address = addr;
    a_mask = mask; a_data = data; a_source = src;
    waits = 0;
    forever begin
      @(negedge clock);
      if (a_ready) break;
      waits++;
      if (waits > 200) begin
        total++; bad++;
        $display("FAIL a_ready_timeout: waited %0d cycles expected acceptance", waits);
        break;
      end
    end
    exp_q.push_back(exp);
    @(posedge clock); #1;
    a_valid = 1'b0;
    chk("d_valid_after_fire", 64'(d_valid), 64'd1);
  endtask

  int w;
  int i;

  initial begin
    // Reset state.
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_d_valid", 64'(d_valid), 64'd0);
    chk("rst_a_ready", 64'(a_ready), 64'd1);
    chk("rst_d_fields", 64'({d_opcode, d_denied, d_corrupt, d_data}), 64'd0);

    // Full write then read back.
    send(3'd0, 2'd2, BASE + 32'h10, 4'hF, 32'hDEADBEEF, 4'd3, mk(3'd0, 2'd2, 4'd3, 1'b0, 1'b0, 32'd0), w);
    send(3'd4, 2'd2, BASE + 32'h10, 4'hF, 32'd0, 4'd5, mk(3'd1, 2'd2, 4'd5, 1'b0, 1'b0, 32'hDEADBEEF), w);
    // Partial write lanes 0 and 2.
    send(3'd1, 2'd2, BASE + 32'h10, 4'b0101, 32'h11223344, 4'd1, mk(3'd0, 2'd2, 4'd1, 1'b0, 1'b0, 32'd0), w);
    send(3'd4, 2'd2, BASE + 32'h10, 4'h0, 32'd0, 4'd2, mk(3'd1, 2'd2, 4'd2, 1'b0, 1'b0, 32'hDE22BE44), w);

    // Refused requests.
    send(3'd4, 2'd2, BASE + 32'h400, 4'hF, 32'd0, 4'd7, mk(3'd1, 2'd2, 4'd7, 1'b1, 1'b1, 32'd0), w);
    send(3'd0, 2'd2, BASE + 32'h2, 4'hF, 32'h1, 4'd8, mk(3'd0, 2'd2, 4'd8, 1'b1, 1'b0, 32'd0), w);
    send(3'd6, 2'd2, BASE + 32'h10, 4'hF, 32'h2, 4'd9, mk(3'd0, 2'd2, 4'd9, 1'b1, 1'b0, 32'd0), w);
    send(3'd4, 2'd3, BASE + 32'h10, 4'hF, 32'd0, 4'd10, mk(3'd1, 2'd3, 4'd10, 1'b1, 1'b1, 32'd0), w);
    send(3'd4, 2'd2, BASE - 32'h4, 4'hF, 32'd0, 4'd11, mk(3'd1, 2'd2, 4'd11, 1'b1, 1'b1, 32'd0), w);
    send(3'd0, 2'd1, BASE + 32'h11, 4'h3, 32'h3, 4'd12, mk(3'd0, 2'd1, 4'd12, 1'b1, 1'b0, 32'd0), w);

    // Last word of the region, including a byte write into the top lane.
    send(3'd0, 2'd2, BASE + 32'h3FC, 4'hF, 32'h12345678, 4'd0, mk(3'd0, 2'd2, 4'd0, 1'b0, 1'b0, 32'd0), w);
    send(3'd1, 2'd0, BASE + 32'h3FF, 4'b1000, 32'hAA000000, 4'd1, mk(3'd0, 2'd0, 4'd1, 1'b0, 1'b0, 32'd0), w);
    send(3'd4, 2'd0, BASE + 32'h3FF, 4'b1000, 32'd0, 4'd2, mk(3'd1, 2'd0, 4'd2, 1'b0, 1'b0, 32'hAA345678), w);
    // Denied write must leave memory untouched.
    send(3'd4, 2'd2, BASE + 32'h10, 4'hF, 32'd0, 4'd3, mk(3'd1, 2'd2, 4'd3, 1'b0, 1'b0, 32'hDE22BE44), w);

    // Back-to-back traffic at full rate.
    for (int k = 0; k < 3; k++) begin
      send(3'd0, 2'd2, BASE + 32'h20 + 32'(k * 4), 4'hF, 32'hA0A0A0A0 + 32'(k), 4'(k),
           mk(3'd0, 2'd2, 4'(k), 1'b0, 1'b0, 32'd0), w);
      chk("b2b_put_no_stall", 64'(w), 64'd0);
    end
    for (int k = 0; k < 3; k++) begin
      send(3'd4, 2'd2, BASE + 32'h20 + 32'(k * 4), 4'hF, 32'd0, 4'(k + 4),
           mk(3'd1, 2'd2, 4'(k + 4), 1'b0, 1'b0, 32'hA0A0A0A0 + 32'(k)), w);
      chk("b2b_get_no_stall", 64'(w), 64'd0);
    end
    @(posedge clock); #1;

    // Stalled response holds its fields and blocks channel A.
    d_ready = 1'b0;
    a_opcode = 3'd4;
    send(3'd4, 2'd2, BASE + 32'h20, 4'hF, 32'd0, 4'd6, mk(3'd1, 2'd2, 4'd6, 1'b0, 1'b0, 32'hA0A0A0A0), w);
    a_valid = 1'b1; a_address = BASE + 32'h24;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("stall_a_ready", 64'(a_ready), 64'd0);
      chk("stall_d_valid", 64'(d_valid), 64'd1);
      chk("stall_d_data", 64'(d_data), 64'hA0A0A0A0);
    end
    @(posedge clock); #1;
    a_valid = 1'b0;
    d_ready = 1'b1;
    @(posedge clock); #1;

    // Reset while a response is stalled: it is dropped.
    d_ready = 1'b0;
    send(3'd4, 2'd2, BASE + 32'h24, 4'hF, 32'd0, 4'd7, mk(3'd1, 2'd2, 4'd7, 1'b0, 1'b0, 32'hA0A0A0A1), w);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    chk("midrst_d_valid", 64'(d_valid), 64'd0);
    chk("midrst_a_ready", 64'(a_ready), 64'd1);
    d_ready = 1'b1;

    // A beat offered during reset is ignored: no write, no response.
    reset = 1'b1;
    a_valid = 1'b1; a_opcode = 3'd0; a_size = 2'd2; a_address = BASE + 32'h10;
    a_mask = 4'hF; a_data = 32'h0BAD0BAD; a_source = 4'd1;
    @(posedge clock); #1;
    reset = 1'b0; a_valid = 1'b0;
    chk("rst_fire_no_rsp", 64'(d_valid), 64'd0);
    send(3'd4, 2'd2, BASE + 32'h10, 4'hF, 32'd0, 4'd8, mk(3'd1, 2'd2, 4'd8, 1'b0, 1'b0, 32'hDE22BE44), w);

    // Random traffic over eight words against a reference memory.
    for (int k = 0; k < 8; k++) begin
      model[k] = 32'h5000_0000 + 32'(k);
      send(3'd0, 2'd2, BASE + 32'h40 + 32'(k * 4), 4'hF, model[k], 4'(k),
           mk(3'd0, 2'd2, 4'(k), 1'b0, 1'b0, 32'd0), w);
    end
    rand_mode = 1'b1;
    for (int k = 0; k < 60; k++) begin
      int r;
      logic [31:0] dat;
      logic [3:0]  msk;
      logic [3:0]  src;
      r = $urandom_range(0, 9);
      i = $urandom_range(0, 7);
      dat = $urandom;
      msk = 4'($urandom_range(0, 15));
      src = 4'($urandom_range(0, 15));
      if (r < 3) begin
        model[i] = dat;
        send(3'd0, 2'd2, BASE + 32'h40 + 32'(i * 4), 4'hF, dat, src, mk(3'd0, 2'd2, src, 1'b0, 1'b0, 32'd0), w);
      end else if (r < 5) begin
        for (int b = 0; b < 4; b++) if (msk[b]) model[i][8*b +: 8] = dat[8*b +: 8];
        send(3'd1, 2'd2, BASE + 32'h40 + 32'(i * 4), msk, dat, src, mk(3'd0, 2'd2, src, 1'b0, 1'b0, 32'd0), w);
      end else if (r < 9) begin
        send(3'd4, 2'd2, BASE + 32'h40 + 32'(i * 4), msk, 32'd0, src, mk(3'd1, 2'd2, src, 1'b0, 1'b0, model[i]), w);
      end else begin
        send(3'd6, 2'd2, BASE + 32'h40 + 32'(i * 4), msk, dat, src, mk(3'd0, 2'd2, src, 1'b1, 1'b0, 32'd0), w);
      end
    end
    rand_mode = 1'b0;
    @(posedge clock); #2;
    d_ready = 1'b1;

    // Drain outstanding responses.
    i = 0;
    while (exp_q.size() != 0 && i < 200) begin
      @(posedge clock);
      i++;
    end
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: %0d responses outstanding expected 0", exp_q.size());
    end
    repeat (2) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tl_ul_sram_responder.md
Name: tl_ul_sram_responder

Overview:
- TileLink-UL responder (manager) terminating channel A and driving channel D for a single-beat 32-bit memory region.
- Sits on the far side of an A/D link, the same link the protocol monitors check from the passive side.
- Serves Get, PutFullData and PutPartialData from an internal word-addressed SRAM.
- Any request it cannot serve gets a denied response.

Parameters:
- ADDR_W, 32, A-channel address width.
- SOURCE_W, 4, source ID width.
- DEPTH, 256, number of 32-bit words in the SRAM; power of two.
- BASE_ADDR, 32'h8000_0000, byte base address of the region; aligned to DEPTH*4.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- a_valid  in  1  A request valid.
- a_ready  out  1  A request accepted.
- a_opcode  in  3  0=PutFullData, 1=PutPartialData, 4=Get; all other values unsupported.
- a_param  in  3  ignored (must be 0 per protocol).
- a_size  in  2  log2 of transfer bytes.
- a_source  in  SOURCE_W  requester ID.
- a_address  in  ADDR_W  byte address.
- a_mask  in  4  byte lanes.
- a_data  in  32  write data.
- d_valid  out  1  D response valid.
- d_ready  in  1  D response accepted.
- d_opcode  out  3  0=AccessAck, 1=AccessAckData.
- d_param  out  2  always 0.
- d_size  out  2  echo of a_size.
- d_source  out  SOURCE_W  echo of a_source.
- d_denied  out  1  request refused.
- d_corrupt  out  1  data invalid.
- d_data  out  32  read data.

Behaviour:
- Single response register (state EMPTY/FULL); no other state.
- a_ready = !d_valid || d_ready, combinational. Allows one request per cycle at full throughput; there is no path from a_valid to a_ready.
- A fire = a_valid && a_ready.
- On A fire at cycle N: d_valid=1 from cycle N+1. All d_* fields are registered at the fire and held stable until D fire.
- D fire = d_valid && d_ready:
  - If D fire and A fire occur in the same cycle, d_valid stays 1 with the new fields.
  - If D fire occurs with no A fire, d_valid goes to 0 next cycle.
- Legality check, evaluated at A fire. A request is legal when all of the following hold:
  - opcode is in {0,1,4};
  - a_size <= 2;
  - address is aligned to 1<<a_size;
  - BASE_ADDR <= address < BASE_ADDR + DEPTH*4.
- Illegal request: no SRAM access. d_denied=1. d_opcode is 1 for Get, otherwise 0. For opcodes 2,3,5,6,7, d_opcode=0. d_corrupt=1 iff d_opcode=1. d_data=0.
- Legal PutFullData / PutPartialData:
  - Write byte lanes where a_mask[i]=1 into word (address-BASE_ADDR)>>2 at A fire.
  - Response: d_opcode=0, d_denied=0, d_corrupt=0, d_data=0.
  - a_mask is not cross-checked against size (the monitor owns that check).
- Legal Get:
  - Synchronous read of the addressed word at A fire; the full 32-bit word is returned regardless of mask.
  - d_opcode=1, d_denied=0, d_corrupt=0.
  - d_data is held in the response register while D is stalled.
- Read-after-write: a Get accepted the cycle after a Put to the same word returns the new data (write completes at the Put fire).
- A Get and a Put never fire in the same cycle (one A beat per cycle).
- d_param=0 always. d_size and d_source echo the accepted request.
- Reset (synchronous, also mid-transfer):
  - d_valid=0; all d_* registers=0, so d_opcode=0, d_data=0, d_denied=0, d_corrupt=0.
  - a_ready=1 in the first cycle after reset deasserts.
  - SRAM contents are not reset. A pending response is dropped silently.
  - A fire in the same cycle as reset is ignored: no write, no response.
- Outputs never depend combinationally on a_* except a_ready's dependence on d_ready.

Test Plan:
- PutFullData addr=0x8000_0010, mask=4'hF, data=0xDEADBEEF, source=3; then Get same address, source=5 -> AccessAck (source 3, denied 0), then AccessAckData data=0xDEADBEEF, source=5, size=2, each one cycle after its A fire.
- PutPartialData mask=4'b0101, data=0x11223344 onto word 0xDEADBEEF; then Get -> d_data=0xDE22BE44.
- Get addr=0x8000_0400 with DEPTH=256 (out of range) -> d_opcode=1, d_denied=1, d_corrupt=1, d_data=0. Put size=2 addr=0x8000_0002 (misaligned) -> d_opcode=0, d_denied=1. Opcode 6 -> AccessAck denied=1.
- Back-to-back Gets with d_ready=1 constantly -> one response per cycle, a_ready never drops. With d_ready=0 for 5 cycles -> a_ready=0, and d_valid and d_data stay stable all 5 cycles.
- Assert reset while d_valid=1 and d_ready=0 -> next cycle d_valid=0, a_ready=1. A Get of a previously written word returns the pre-reset data.
- Random A traffic with random d_ready, checked by the channel A/D protocol monitor and a reference memory model -> zero monitor errors, all data matches.
